flit_assembler: RTL and testbench

Receive-side counterpart of the node splitter. It accepts 17-bit-payload flits from the network router port and reassembles the four flits of each 68-bit packet in per-source slots. Completed packets are queued in an output FIFO toward the local core, tagged with source node and packet ID. It sits between the router local-eject port and the core's packet input.

---
 rtl/noc_pkg.sv | 58 +++++
 rtl/assembler_fifo.sv | 51 +++++
 rtl/flit_assembler.sv | 154 +++++++++++++++
 tb/tb_flit_assembler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, node encoding and packet slice positions.
// Used by both the node splitter and the flit assembler.
package noc_pkg;

    localparam int PAYLOAD_W = 17;
    localparam int IDX_W     = 2;
    localparam int PACKET_W  = 68;

    // Bit position of the lowest payload bit for each flit index
    localparam int SLICE_LO_0 = 51;
    localparam int SLICE_LO_1 = 34;
    localparam int SLICE_LO_2 = 17;
    localparam int SLICE_LO_3 = 0;

    localparam int IDX_LSB = 0;
    localparam int SRC_LSB = IDX_W;

    function automatic int flit_width(input int l, input int p);
        return 1 + 2 * l + PAYLOAD_W + p + IDX_W;
    endfunction

    function automatic int id_lsb(input int l);
        return SRC_LSB + l;
    endfunction

    function automatic int payload_lsb(input int l, input int p);
        return SRC_LSB + l + p;
    endfunction

    function automatic int dest_lsb(input int l, input int p);
        return SRC_LSB + l + p + PAYLOAD_W;
    endfunction

    function automatic int valid_bit(input int l, input int p);
        return SRC_LSB + 2 * l + p + PAYLOAD_W;
    endfunction

    function automatic int slice_lo(input logic [1:0] idx);
        int lo;
        case (idx)
            2'd0:    lo = SLICE_LO_0;
            2'd1:    lo = SLICE_LO_1;
            2'd2:    lo = SLICE_LO_2;
            default: lo = SLICE_LO_3;
        endcase
        return lo;
    endfunction

    // Mesh coordinate code {x[1:0], y[1:0]}; callers truncate to L bits
    function automatic logic [3:0] encode_node(input int n);
        int x;
        int y;
        x = n % 3;
        y = n / 3;
        return {x[1:0], y[1:0]};
    endfunction

endpackage

// File: rtl/assembler_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; push and pop
// only take effect while ce is high. DEPTH must be a power of two.
module assembler_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             do_push;
    logic             do_pop;

    assign do_push = ce && push && (count < CW'(DEPTH));
    assign do_pop  = ce && pop && (count != '0);
    assign dout    = mem[head];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= din;
    end

endmodule

// File: rtl/flit_assembler.sv
// Reassembles four 17-bit flits per source into 68-bit packets and queues them
// toward the core. Define FLIT_ASSEMBLER_STATS_EN to add drop_count/err_pulse.
module flit_assembler
    import noc_pkg::*;
#(
    parameter int NODE_ID         = 0,
    parameter int NODE_COUNT      = 8,
    parameter int QUEUE_DEPTH     = 8,
    parameter int PACKET_ID_WIDTH = 5
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   ce,
    input  logic [flit_width($clog2(NODE_COUNT), PACKET_ID_WIDTH)-1:0] flit_in,
    input  logic                                   valid_in,
    output logic                                   assembler_ready,
    output logic [PACKET_W-1:0]                    packet_out,
    output logic [$clog2(NODE_COUNT)-1:0]          src_node,
    output logic [PACKET_ID_WIDTH-1:0]             packet_id,
    output logic                                   valid_out,
    input  logic                                   core_ready
`ifdef FLIT_ASSEMBLER_STATS_EN
    ,
    output logic [7:0]                             drop_count,
    output logic                                   err_pulse
`endif
);

    localparam int L         = $clog2(NODE_COUNT);
    localparam int P         = PACKET_ID_WIDTH;
    localparam int EW        = PACKET_W + L + P;
    localparam int CW        = $clog2(QUEUE_DEPTH) + 1;
    localparam int VALID_BIT = valid_bit(L, P);
    localparam int DEST_LSB  = dest_lsb(L, P);
    localparam int PL_LSB    = payload_lsb(L, P);
    localparam int ID_LSB    = id_lsb(L);
    localparam logic [L-1:0]        MY_DEST = L'(encode_node(NODE_ID));
    localparam logic [PACKET_W-1:0] LANE    = PACKET_W'(17'h1FFFF);

    logic [L-1:0]         f_dest;
    logic [PAYLOAD_W-1:0] f_payload;
    logic [P-1:0]         f_id;
    logic [L-1:0]         f_src;
    logic [1:0]           f_idx;

    assign f_dest    = flit_in[DEST_LSB +: L];
    assign f_payload = flit_in[PL_LSB +: PAYLOAD_W];
    assign f_id      = flit_in[ID_LSB +: P];
    assign f_src     = flit_in[SRC_LSB +: L];
    assign f_idx     = flit_in[IDX_LSB +: IDX_W];

    logic [PACKET_W-1:0] slot_payload [NODE_COUNT];
    logic [P-1:0]        slot_id      [NODE_COUNT];
    logic [3:0]          slot_mask    [NODE_COUNT];

    logic                accept;
    logic                dest_ok;
    logic                src_ok;
    logic [L-1:0]        src_idx;
    logic [3:0]          cur_mask;
    logic [P-1:0]        cur_id;
    logic [3:0]          idx_bit;
    logic [PACKET_W-1:0] placed;
    logic                slot_wr;
    logic [3:0]          nxt_mask;
    logic [P-1:0]        nxt_id;
    logic                push;
    logic                pop;
    logic [EW-1:0]       fifo_dout;
    logic [CW-1:0]       fifo_count;

    assign assembler_ready = ce && (fifo_count < CW'(QUEUE_DEPTH));
    assign accept   = valid_in && flit_in[VALID_BIT] && assembler_ready;
    assign dest_ok  = (f_dest == MY_DEST);
    assign src_ok   = (int'(f_src) < NODE_COUNT);
    assign src_idx  = src_ok ? f_src : '0;
    assign cur_mask = slot_mask[src_idx];
    assign cur_id   = slot_id[src_idx];
    assign idx_bit  = 4'b0001 << f_idx;
    assign placed   = (slot_payload[src_idx] & ~(LANE << slice_lo(f_idx)))
                    | (PACKET_W'(f_payload) << slice_lo(f_idx));

    // A new id (or an empty slot) restarts the slot; duplicates leave it untouched
    always_comb begin
        slot_wr  = 1'b0;
        nxt_mask = cur_mask;
        nxt_id   = cur_id;
        push     = 1'b0;
        if (accept && dest_ok && src_ok) begin
            if (cur_mask == 4'b0000 || cur_id != f_id) begin
                slot_wr  = 1'b1;
                nxt_mask = idx_bit;
                nxt_id   = f_id;
            end else if ((cur_mask & idx_bit) == 4'b0000) begin
                slot_wr  = 1'b1;
                nxt_mask = cur_mask | idx_bit;
            end
        end
        push = slot_wr && (nxt_mask == 4'b1111);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NODE_COUNT; i++) slot_mask[i] <= 4'b0000;
        end else if (slot_wr) begin
            slot_mask[src_idx] <= push ? 4'b0000 : nxt_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (slot_wr) begin
            slot_payload[src_idx] <= placed;
            slot_id[src_idx]      <= nxt_id;
        end
    end

    assign pop = valid_out && core_ready && ce;

    assembler_fifo #(
        .WIDTH (EW),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .push  (push),
        .pop   (pop),
        .din   ({placed, f_src, nxt_id}),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign valid_out = (fifo_count != '0);
    assign {packet_out, src_node, packet_id} = valid_out ? fifo_dout : '0;

`ifdef FLIT_ASSEMBLER_STATS_EN
    logic err;

    // Routing errors, duplicate indices and discarded partials all count as drops
    assign err = accept && (!dest_ok || !src_ok ||
                 (cur_mask != 4'b0000 && (cur_id != f_id || (cur_mask & idx_bit) != 4'b0000)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= 8'd0;
            err_pulse  <= 1'b0;
        end else if (ce) begin
            err_pulse <= err;
            if (err && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_flit_assembler.sv
// Directed self-checking bench for flit_assembler (NODE_ID=0, 8 nodes, depth 8, 5-bit ids).
// Honours FLIT_ASSEMBLER_STATS_EN when the design is built with it.
module tb_flit_assembler;

    localparam int L  = 3;
    localparam int P  = 5;
    localparam int FW = 1 + 2 * L + 17 + P + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic [FW-1:0] flit_in;
    logic          valid_in;
    logic          assembler_ready;
    logic [67:0]   packet_out;
    logic [L-1:0]  src_node;
    logic [P-1:0]  packet_id;
    logic          valid_out;
    logic          core_ready;
`ifdef FLIT_ASSEMBLER_STATS_EN
    logic [7:0]    drop_count;
    logic          err_pulse;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flit_assembler #(
        .NODE_ID         (0),
        .NODE_COUNT      (8),
        .QUEUE_DEPTH     (8),
        .PACKET_ID_WIDTH (5)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ce              (ce),
        .flit_in         (flit_in),
        .valid_in        (valid_in),
        .assembler_ready (assembler_ready),
        .packet_out      (packet_out),
        .src_node        (src_node),
        .packet_id       (packet_id),
        .valid_out       (valid_out),
        .core_ready      (core_ready)
`ifdef FLIT_ASSEMBLER_STATS_EN
        ,
        .drop_count      (drop_count),
        .err_pulse       (err_pulse)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [2:0] dest, input logic [16:0] pl,
                                         input logic [4:0] id, input logic [2:0] src,
                                         input logic [1:0] idx);
        return {1'b1, dest, pl, id, src, idx};
    endfunction

    function automatic logic [67:0] exp_pkt(input logic [16:0] base);
        return {base, base + 17'd1, base + 17'd2, base + 17'd3};
    endfunction

    task automatic send(input logic [FW-1:0] f, input logic with_pop);
        @(negedge clk);
        flit_in    = f;
        valid_in   = 1'b1;
        core_ready = with_pop;
        @(posedge clk);
        #1;
        valid_in   = 1'b0;
        core_ready = 1'b0;
        flit_in    = '0;
    endtask

    task automatic pop_one();
        @(negedge clk);
        core_ready = 1'b1;
        @(posedge clk);
        #1;
        core_ready = 1'b0;
    endtask

    task automatic send_pkt(input logic [2:0] src, input logic [4:0] id, input logic [16:0] base);
        for (int i = 0; i < 4; i++)
            send(mk(3'd0, base + 17'(i), id, src, 2'(i)), 1'b0);
    endtask

    task automatic expect_head(input string tag, input logic [2:0] src, input logic [4:0] id,
                               input logic [67:0] pkt);
        check({tag, ".valid"}, valid_out, 1'b1);
        check({tag, ".src"}, src_node, src);
        check({tag, ".id"}, packet_id, id);
        check({tag, ".pkt"}, packet_out, pkt);
    endtask

    initial begin
        rst_n      = 1'b0;
        ce         = 1'b0;
        valid_in   = 1'b0;
        flit_in    = '0;
        core_ready = 1'b0;
        #12;
        check("rst_ready_ce0", assembler_ready, 1'b0);
        ce = 1'b1;
        #1;
        check("rst_ready", assembler_ready, 1'b1);
        check("rst_valid", valid_out, 1'b0);
        check("rst_pkt", packet_out, 68'h0);
        check("rst_src", src_node, 3'd0);
        check("rst_id", packet_id, 5'd0);
`ifdef FLIT_ASSEMBLER_STATS_EN
        check("rst_drops", drop_count, 8'd0);
        check("rst_errp", err_pulse, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // In-order packet
        send(mk(3'd0, 17'h1AAAA, 5'd5, 3'd2, 2'd0), 1'b0);
        send(mk(3'd0, 17'h05555, 5'd5, 3'd2, 2'd1), 1'b0);
        send(mk(3'd0, 17'h0F0F0, 5'd5, 3'd2, 2'd2), 1'b0);
        check("inorder_pending", valid_out, 1'b0);
        send(mk(3'd0, 17'h00001, 5'd5, 3'd2, 2'd3), 1'b0);
        expect_head("inorder", 3'd2, 5'd5, {17'h1AAAA, 17'h05555, 17'h0F0F0, 17'h00001});

        // ce low: no accept, no pop, outputs hold
        @(negedge clk);
        ce = 1'b0;
        #1;
        check("ce0_ready", assembler_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            flit_in    = mk(3'd0, 17'h00777, 5'd1, 3'd7, 2'(i));
            valid_in   = 1'b1;
            core_ready = 1'b1;
        end
        @(negedge clk);
        valid_in   = 1'b0;
        core_ready = 1'b0;
        ce         = 1'b1;
        #1;
        expect_head("ce0_hold", 3'd2, 5'd5, {17'h1AAAA, 17'h05555, 17'h0F0F0, 17'h00001});
        pop_one();
        check("ce0_no_accept", valid_out, 1'b0);

        // Out-of-order and interleaved
        send(mk(3'd0, 17'h11003, 5'd7, 3'd1, 2'd3), 1'b0);
        send(mk(3'd0, 17'h04400, 5'd9, 3'd4, 2'd0), 1'b0);
        send(mk(3'd0, 17'h11001, 5'd7, 3'd1, 2'd1), 1'b0);
        send(mk(3'd0, 17'h04401, 5'd9, 3'd4, 2'd1), 1'b0);
        send(mk(3'd0, 17'h11000, 5'd7, 3'd1, 2'd0), 1'b0);
        send(mk(3'd0, 17'h04402, 5'd9, 3'd4, 2'd2), 1'b0);
        check("ooo_pending", valid_out, 1'b0);
        send(mk(3'd0, 17'h11002, 5'd7, 3'd1, 2'd2), 1'b0);
        expect_head("ooo_first", 3'd1, 5'd7, exp_pkt(17'h11000));
        send(mk(3'd0, 17'h04403, 5'd9, 3'd4, 2'd3), 1'b0);
        expect_head("ooo_still_first", 3'd1, 5'd7, exp_pkt(17'h11000));
        pop_one();
        expect_head("ooo_second", 3'd4, 5'd9, exp_pkt(17'h04400));
        pop_one();
        check("ooo_empty", valid_out, 1'b0);

        // Backpressure: fill the queue
        for (int k = 0; k < 8; k++) begin
            send_pkt(3'd3, 5'(k), 17'h01000 + 17'(k * 16));
            if (k == 6) check("bp_ready_7", assembler_ready, 1'b1);
        end
        check("bp_ready_full", assembler_ready, 1'b0);
        pop_one();
        check("bp_ready_after_pop", assembler_ready, 1'b1);
        for (int k = 1; k < 8; k++) begin
            expect_head($sformatf("bp_drain%0d", k), 3'd3, 5'(k), exp_pkt(17'h01000 + 17'(k * 16)));
            pop_one();
        end
        check("bp_empty", valid_out, 1'b0);

        // Simultaneous push and pop with count = depth-1
        for (int k = 0; k < 7; k++) send_pkt(3'd5, 5'(10 + k), 17'h02000 + 17'(k * 16));
        send(mk(3'd0, 17'h03000, 5'd17, 3'd5, 2'd0), 1'b0);
        send(mk(3'd0, 17'h03001, 5'd17, 3'd5, 2'd1), 1'b0);
        send(mk(3'd0, 17'h03002, 5'd17, 3'd5, 2'd2), 1'b0);
        send(mk(3'd0, 17'h03003, 5'd17, 3'd5, 2'd3), 1'b1);
        check("pp_ready", assembler_ready, 1'b1);
        for (int k = 1; k < 8; k++) begin
            expect_head($sformatf("pp_drain%0d", k), 3'd5, 5'(10 + k),
                        (k < 7) ? exp_pkt(17'h02000 + 17'(k * 16)) : exp_pkt(17'h03000));
            pop_one();
        end
        check("pp_empty", valid_out, 1'b0);

        // Errors: wrong dest, duplicate idx, id change mid-packet
        send(mk(3'd1, 17'h0AAAA, 5'd2, 3'd6, 2'd0), 1'b0);
        send(mk(3'd0, 17'h00111, 5'd2, 3'd6, 2'd0), 1'b0);
        send(mk(3'd0, 17'h00222, 5'd2, 3'd6, 2'd1), 1'b0);
        send(mk(3'd0, 17'h00333, 5'd2, 3'd6, 2'd1), 1'b0);
        send(mk(3'd0, 17'h0A000, 5'd3, 3'd6, 2'd0), 1'b0);
        send(mk(3'd0, 17'h0A001, 5'd3, 3'd6, 2'd1), 1'b0);
        send(mk(3'd0, 17'h0A002, 5'd3, 3'd6, 2'd2), 1'b0);
        check("err_pending", valid_out, 1'b0);
        send(mk(3'd0, 17'h0A003, 5'd3, 3'd6, 2'd3), 1'b0);
        expect_head("err_pkt", 3'd6, 5'd3, exp_pkt(17'h0A000));
`ifdef FLIT_ASSEMBLER_STATS_EN
        check("err_drops", drop_count, 8'd3);
`endif
        pop_one();
        check("err_empty", valid_out, 1'b0);

        // Reset mid-operation
        send_pkt(3'd0, 5'd4, 17'h04000);
        send(mk(3'd0, 17'h05000, 5'd1, 3'd2, 2'd0), 1'b0);
        send(mk(3'd0, 17'h05001, 5'd1, 3'd2, 2'd1), 1'b0);
        check("mid_queued", valid_out, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", valid_out, 1'b0);
        check("mid_rst_pkt", packet_out, 68'h0);
        check("mid_rst_src", src_node, 3'd0);
        check("mid_rst_id", packet_id, 5'd0);
        check("mid_rst_ready", assembler_ready, 1'b1);
`ifdef FLIT_ASSEMBLER_STATS_EN
        check("mid_rst_drops", drop_count, 8'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        send(mk(3'd0, 17'h05002, 5'd1, 3'd2, 2'd2), 1'b0);
        send(mk(3'd0, 17'h05003, 5'd1, 3'd2, 2'd3), 1'b0);
        check("mid_no_packet", valid_out, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
